// File: rtl/rf_wb_pkg.sv
// rf_wb_pkg: shared constants and types for the register-file write-back scheduler.
`default_nettype none

package rf_wb_pkg;

   localparam int unsigned NREG_DEF = 32;
   localparam int unsigned DW_DEF   = 32;
   localparam int unsigned RA_W     = 5;

   localparam logic [RA_W-1:0] REG_ZERO = 5'd0;

   // Enum value doubles as the bit position of that producer in request/grant vectors.
   typedef enum logic [0:0] {
      WB_ALU = 1'b0,
      WB_MEM = 1'b1
   } wb_src_e;

endpackage

`default_nettype wire

// File: rtl/wb_arb2.sv
// wb_arb2: two-requester arbiter (ALU / MEM), one-hot grant, combinational from requests.
// Macro RF_WB_RR_EN selects round-robin; otherwise fixed priority MEM over ALU.
`default_nettype none

module wb_arb2
   import rf_wb_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] i_req,
   output logic [1:0] o_gnt
);

`ifdef RF_WB_RR_EN
   wb_src_e r_last;

   // Reset to ALU so the first contended cycle goes to MEM.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last <= WB_ALU;
      end else if (|o_gnt) begin
         r_last <= o_gnt[WB_MEM] ? WB_MEM : WB_ALU;
      end
   end

   always_comb begin
      o_gnt = 2'b00;
      if (i_req[WB_MEM] && i_req[WB_ALU]) begin
         if (r_last == WB_MEM) begin
            o_gnt[WB_ALU] = 1'b1;
         end else begin
            o_gnt[WB_MEM] = 1'b1;
         end
      end else begin
         o_gnt = i_req;
      end
   end
`else
   logic w_unused;
   assign w_unused = clk ^ rst;

   always_comb begin
      o_gnt = 2'b00;
      if (i_req[WB_MEM]) begin
         o_gnt[WB_MEM] = 1'b1;
      end else begin
         o_gnt[WB_ALU] = i_req[WB_ALU];
      end
   end
`endif

endmodule

`default_nettype wire

// File: rtl/rf_wb_scheduler.sv
// rf_wb_scheduler: arbitrates ALU/load write-backs onto the register-file write port and
// keeps a pending-write scoreboard for hazard stalls. Macro RF_WB_RR_EN enables round-robin.
`default_nettype none

module rf_wb_scheduler
   import rf_wb_pkg::*;
#(
   parameter int unsigned NREG = NREG_DEF,
   parameter int unsigned DW   = DW_DEF
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          i_alu_valid,
   input  logic [4:0]    i_alu_wr,
   input  logic [DW-1:0] i_alu_wd,
   output logic          o_alu_ready,
   input  logic          i_mem_valid,
   input  logic [4:0]    i_mem_wr,
   input  logic [DW-1:0] i_mem_wd,
   output logic          o_mem_ready,
   input  logic          i_rsv_valid,
   input  logic [4:0]    i_rsv_wr,
   output logic          o_rsv_ready,
   input  logic [4:0]    i_rr1,
   input  logic [4:0]    i_rr2,
   output logic          o_rr1_busy,
   output logic          o_rr2_busy,
   output logic          o_rf_write,
   output logic [4:0]    o_rf_wr,
   output logic [DW-1:0] o_rf_wd,
   output logic          o_sb_err
);

   logic [NREG-1:0] r_pending;
   logic [NREG-1:0] w_pend_nxt;
   logic            r_rf_write;
   logic [4:0]      r_rf_wr;
   logic [DW-1:0]   r_rf_wd;
   logic            r_sb_err;

   logic [1:0]      w_req;
   logic [1:0]      w_gnt;
   wb_src_e         w_src;
   logic            w_acc;
   logic [4:0]      w_wr;
   logic [DW-1:0]   w_wd;
   logic            w_rsv_ready;
   logic            w_rsv_acc;
   logic            w_err_set;

   assign w_req[WB_ALU] = i_alu_valid;
   assign w_req[WB_MEM] = i_mem_valid;

   wb_arb2 u_arb (
      .clk   (clk),
      .rst   (rst),
      .i_req (w_req),
      .o_gnt (w_gnt)
   );

   assign o_alu_ready = w_gnt[WB_ALU];
   assign o_mem_ready = w_gnt[WB_MEM];

   assign w_src = w_gnt[WB_MEM] ? WB_MEM : WB_ALU;
   assign w_acc = |w_gnt;
   assign w_wr  = (w_src == WB_MEM) ? i_mem_wr : i_alu_wr;
   assign w_wd  = (w_src == WB_MEM) ? i_mem_wd : i_alu_wd;

   // Register 0 is never marked pending, so its reservations always pass.
   assign w_rsv_ready = !r_pending[i_rsv_wr];
   assign w_rsv_acc   = i_rsv_valid && w_rsv_ready && (i_rsv_wr != REG_ZERO);
   assign o_rsv_ready = w_rsv_ready;

   assign o_rr1_busy = (i_rr1 != REG_ZERO) && r_pending[i_rr1];
   assign o_rr2_busy = (i_rr2 != REG_ZERO) && r_pending[i_rr2];

   assign w_err_set = w_acc && (w_wr != REG_ZERO) && !r_pending[w_wr];

   // Clear follows the registered write so busy drops when the reg_file read sees new data.
   always_comb begin
      w_pend_nxt = r_pending;
      if (r_rf_write) begin
         w_pend_nxt[r_rf_wr] = 1'b0;
      end
      if (w_rsv_acc) begin
         w_pend_nxt[i_rsv_wr] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= '0;
         r_rf_write <= 1'b0;
         r_rf_wr    <= 5'd0;
         r_rf_wd    <= '0;
         r_sb_err   <= 1'b0;
      end else begin
         r_pending  <= w_pend_nxt;
         r_rf_write <= w_acc && (w_wr != REG_ZERO);
         if (w_acc) begin
            r_rf_wr <= w_wr;
            r_rf_wd <= w_wd;
         end
         if (w_err_set) begin
            r_sb_err <= 1'b1;
         end
      end
   end

   assign o_rf_write = r_rf_write;
   assign o_rf_wr    = r_rf_wr;
   assign o_rf_wd    = r_rf_wd;
   assign o_sb_err   = r_sb_err;

endmodule

`default_nettype wire
